// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand/opcode sequencer.
// Holds the FSM state encoding, the opcode constants the ALU understands,
// and is_valid_op(), which the optional opcode check (ALU_SEQ_OPCHECK_EN) uses.
package alu_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned OP_W    = 6;

    typedef enum logic [STATE_W-1:0] {
        S_LOAD_A  = 3'd0,
        S_LOAD_B  = 3'd1,
        S_LOAD_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_SHOW    = 3'd4
    } state_e;

    localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
    localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
    localparam logic [OP_W-1:0] OP_AND = 6'b100100;
    localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
    localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
    localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
    localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
    localparam logic [OP_W-1:0] OP_SRL = 6'b000010;

    // True when op is one of the opcodes the ALU implements.
    function automatic logic is_valid_op(input logic [OP_W-1:0] op);
        logic ok;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, symmetric debounce and rising-edge pulse.
// Ports:
//   clock, reset  - system clock, synchronous active-high reset
//   i_btn         - raw button, asynchronous to clock
//   o_pulse       - one-cycle pulse on the debounced 0->1 edge
// The debounced level flips after DB_CYCLES consecutive synchronised samples
// that disagree with it; a raw press produces o_pulse 2 + DB_CYCLES cycles later.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             pulse_q, pulse_d;

    // Count disagreeing samples; any agreeing sample restarts the run.
    always_comb begin
        sync1_d = i_btn;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        pulse_d = level_d & ~level_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign o_pulse = pulse_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Single-button sequencer that loads A, B and OP from the switches, waits out
// the ALU latency, then latches and holds the ALU result for the LEDs.
// Ports:
//   clock, reset          - system clock, synchronous active-high reset
//   i_SWs                 - switch value captured on each "next" press
//   i_btn_next, i_btn_clr - raw buttons (conditioned internally)
//   i_alu_res             - ALU result
//   o_A, o_B, o_OP        - operand/opcode registers driving the ALU
//   o_led                 - held result, o_done high while it is valid
//   o_state               - current FSM state code for debug LEDs
//   o_op_err              - only with ALU_SEQ_OPCHECK_EN: last opcode was rejected
// Build option: define ALU_SEQ_OPCHECK_EN to reject opcodes not in alu_pkg.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned N_BITS    = 6,
    parameter int unsigned DB_CYCLES = 16,
    parameter int unsigned ALU_LAT   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_BITS-1:0] i_SWs,
    input  logic              i_btn_next,
    input  logic              i_btn_clr,
    input  logic [N_BITS-1:0] i_alu_res,
    output logic [N_BITS-1:0] o_A,
    output logic [N_BITS-1:0] o_B,
    output logic [N_BITS-1:0] o_OP,
    output logic [N_BITS-1:0] o_led,
`ifdef ALU_SEQ_OPCHECK_EN
    output logic              o_op_err,
`endif
    output logic [2:0]        o_state,
    output logic              o_done
);

    localparam int unsigned WAIT_W = 4;

    logic next_pulse;
    logic clr_pulse;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_next (
        .clock   (clock),
        .reset   (reset),
        .i_btn   (i_btn_next),
        .o_pulse (next_pulse)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clock   (clock),
        .reset   (reset),
        .i_btn   (i_btn_clr),
        .o_pulse (clr_pulse)
    );

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q,  wait_d;
    logic [N_BITS-1:0]   a_q,     a_d;
    logic [N_BITS-1:0]   b_q,     b_d;
    logic [N_BITS-1:0]   op_q,    op_d;
    logic [N_BITS-1:0]   led_q,   led_d;
    logic                done_q,  done_d;
    logic                op_ok_c;
`ifdef ALU_SEQ_OPCHECK_EN
    logic                op_err_q, op_err_d;
`endif

    // Opcode acceptance; switch bits above the opcode width must be zero.
`ifdef ALU_SEQ_OPCHECK_EN
    assign op_ok_c = is_valid_op(OP_W'(i_SWs)) && ((i_SWs >> OP_W) == '0);
`else
    assign op_ok_c = 1'b1;
`endif

    // Next-state and register-load logic; clear overrides next.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        led_d   = led_q;
        done_d  = done_q;
`ifdef ALU_SEQ_OPCHECK_EN
        op_err_d = op_err_q;
`endif
        if (clr_pulse) begin
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
            led_d   = '0;
            done_d  = 1'b0;
            wait_d  = '0;
            state_d = S_LOAD_A;
`ifdef ALU_SEQ_OPCHECK_EN
            op_err_d = 1'b0;
`endif
        end else begin
            case (state_q)
                S_LOAD_A: begin
                    if (next_pulse) begin
                        a_d     = i_SWs;
                        state_d = S_LOAD_B;
`ifdef ALU_SEQ_OPCHECK_EN
                        op_err_d = 1'b0;
`endif
                    end
                end
                S_LOAD_B: begin
                    if (next_pulse) begin
                        b_d     = i_SWs;
                        state_d = S_LOAD_OP;
`ifdef ALU_SEQ_OPCHECK_EN
                        op_err_d = 1'b0;
`endif
                    end
                end
                S_LOAD_OP: begin
                    if (next_pulse) begin
                        if (op_ok_c) begin
                            op_d    = i_SWs;
                            wait_d  = WAIT_W'(ALU_LAT);
                            state_d = S_EXEC;
`ifdef ALU_SEQ_OPCHECK_EN
                            op_err_d = 1'b0;
                        end else begin
                            op_err_d = 1'b1;
`endif
                        end
                    end
                end
                S_EXEC: begin
                    // Presses are ignored here; the result is taken once the wait expires.
                    if (wait_q == '0) begin
                        led_d   = i_alu_res;
                        done_d  = 1'b1;
                        state_d = S_SHOW;
                    end else begin
                        wait_d = wait_q - WAIT_W'(1);
                    end
                end
                S_SHOW: begin
                    if (next_pulse) begin
                        done_d  = 1'b0;
                        state_d = S_LOAD_A;
                    end
                end
                default: begin
                    state_d = S_LOAD_A;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_LOAD_A;
            wait_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            led_q   <= '0;
            done_q  <= 1'b0;
`ifdef ALU_SEQ_OPCHECK_EN
            op_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            led_q   <= led_d;
            done_q  <= done_d;
`ifdef ALU_SEQ_OPCHECK_EN
            op_err_q <= op_err_d;
`endif
        end
    end

    assign o_A     = a_q;
    assign o_B     = b_q;
    assign o_OP    = op_q;
    assign o_led   = led_q;
    assign o_done  = done_q;
    assign o_state = state_q;
`ifdef ALU_SEQ_OPCHECK_EN
    assign o_op_err = op_err_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed scenarios plus a randomized press
// sequence compared against a per-press reference model of the sequencer.
module tb_alu_op_sequencer;

    localparam int unsigned N   = 6;
    localparam int unsigned DB  = 4;
    localparam int unsigned LAT = 4;

    localparam logic [5:0] T_ADD = 6'b100000;
    localparam logic [5:0] T_SUB = 6'b100010;
    localparam logic [5:0] VALID_OPS [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                             6'b100110, 6'b100111, 6'b000011, 6'b000010};

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] i_SWs = '0;
    logic         raw_next = 1'b0;
    logic         raw_clr = 1'b0;
    logic [N-1:0] alu_q = '0;
    logic [N-1:0] o_A, o_B, o_OP, o_led;
    logic [2:0]   o_state;
    logic         o_done;
`ifdef ALU_SEQ_OPCHECK_EN
    logic         o_op_err;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state, advanced once per accepted button press.
    int           m_state;
    logic [N-1:0] m_a, m_b, m_op, m_led;
    logic         m_done;
    logic         m_err;

    always #5 clk = ~clk;

    alu_op_sequencer #(.N_BITS(N), .DB_CYCLES(DB), .ALU_LAT(LAT)) dut (
        .clock      (clk),
        .reset      (reset),
        .i_SWs      (i_SWs),
        .i_btn_next (raw_next),
        .i_btn_clr  (raw_clr),
        .i_alu_res  (alu_q),
        .o_A        (o_A),
        .o_B        (o_B),
        .o_OP       (o_OP),
        .o_led      (o_led),
`ifdef ALU_SEQ_OPCHECK_EN
        .o_op_err   (o_op_err),
`endif
        .o_state    (o_state),
        .o_done     (o_done)
    );

    function automatic logic [N-1:0] alu_fn(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic [N-1:0] op);
        case (op)
            6'b100000: return a + b;
            6'b100010: return a - b;
            6'b100100: return a & b;
            6'b100101: return a | b;
            6'b100110: return a ^ b;
            6'b100111: return ~(a | b);
            6'b000010: return a >> b[2:0];
            6'b000011: return N'($signed(a) >>> b[2:0]);
            default:   return a ^ b ^ op;
        endcase
    endfunction

    // One-cycle-latency ALU stand-in.
    always_ff @(posedge clk) alu_q <= alu_fn(o_A, o_B, o_OP);

    function automatic logic op_valid(input logic [N-1:0] sw);
`ifdef ALU_SEQ_OPCHECK_EN
        for (int i = 0; i < 8; i++) if (VALID_OPS[i] == sw) return 1'b1;
        return 1'b0;
`else
        return (sw == sw);
`endif
    endfunction

    task automatic model_reset();
        m_state = 0; m_a = '0; m_b = '0; m_op = '0; m_led = '0; m_done = 1'b0; m_err = 1'b0;
    endtask

    // Effect of one complete "next" press after the sequencer has settled.
    task automatic model_next(input logic [N-1:0] sw);
        case (m_state)
            0: begin m_a = sw; m_state = 1; m_err = 1'b0; end
            1: begin m_b = sw; m_state = 2; m_err = 1'b0; end
            2: begin
                if (op_valid(sw)) begin
                    m_op = sw; m_err = 1'b0;
                    m_led = alu_fn(m_a, m_b, m_op); m_done = 1'b1; m_state = 4;
                end else begin
                    m_err = 1'b1;
                end
            end
            4: begin m_done = 1'b0; m_state = 0; end
            default: m_state = 0;
        endcase
    endtask

    // Clean press: raw high until just after the capture edge, extra hold, release, settle.
    task automatic press(input logic nxt, input logic clr, input logic [N-1:0] sw, input int hold);
        @(negedge clk);
        i_SWs = sw; raw_next = nxt; raw_clr = clr;
        repeat (DB + 3) @(negedge clk);
        i_SWs = N'($urandom);
        repeat (hold) @(negedge clk);
        raw_next = 1'b0; raw_clr = 1'b0;
        repeat (DB + 4) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_A, o_B, o_OP, o_led} !== '0) begin
            errors++; $display("FAIL reset_regs: got %h expected 0", {o_A, o_B, o_OP, o_led});
        end
        checks++;
        if (o_state !== 3'd0 || o_done !== 1'b0) begin
            errors++; $display("FAIL reset_state: got state=%0d done=%b expected 0/0", o_state, o_done);
        end
`ifdef ALU_SEQ_OPCHECK_EN
        checks++;
        if (o_op_err !== 1'b0) begin errors++; $display("FAIL reset_op_err: got %b expected 0", o_op_err); end
`endif
        reset = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_glitch();
        @(negedge clk);
        i_SWs = 6'd9; raw_next = 1'b1;
        repeat (DB - 1) @(negedge clk);
        raw_next = 1'b0;
        repeat (DB + 6) @(negedge clk);
        checks++;
        if (o_state !== 3'd0 || o_A !== '0) begin
            errors++; $display("FAIL glitch: got state=%0d A=%0d expected 0/0", o_state, o_A);
        end
    endtask

    task automatic test_sequence();
        press(1'b1, 1'b0, 6'd5, 0); model_next(6'd5);
        press(1'b1, 1'b0, 6'd3, 0); model_next(6'd3);
        @(negedge clk);
        i_SWs = T_ADD; raw_next = 1'b1;
        repeat (DB + 2) @(negedge clk);
        checks++;
        if (o_state !== 3'd2) begin errors++; $display("FAIL press_latency_early: got state=%0d expected 2", o_state); end
        @(negedge clk);
        checks++;
        if (o_state !== 3'd3 || o_OP !== 6'h20) begin
            errors++; $display("FAIL op_capture: got state=%0d OP=%h expected 3/20", o_state, o_OP);
        end
        i_SWs = N'($urandom); raw_next = 1'b0;
        repeat (LAT) @(negedge clk);
        checks++;
        if (o_done !== 1'b0 || o_state !== 3'd3) begin
            errors++; $display("FAIL exec_early: got done=%b state=%0d expected 0/3", o_done, o_state);
        end
        @(negedge clk);
        checks++;
        if (o_done !== 1'b1 || o_led !== 6'd8 || o_state !== 3'd4) begin
            errors++; $display("FAIL exec_result: got done=%b led=%0d state=%0d expected 1/8/4", o_done, o_led, o_state);
        end
        checks++;
        if (o_A !== 6'd5 || o_B !== 6'd3) begin
            errors++; $display("FAIL operands: got A=%0d B=%0d expected 5/3", o_A, o_B);
        end
        model_next(T_ADD);
        repeat (DB + 4) @(negedge clk);
    endtask

    task automatic test_show_next();
        press(1'b1, 1'b0, N'($urandom), 20); model_next('0);
        checks++;
        if (o_state !== 3'd0 || o_done !== 1'b0 || o_led !== 6'd8 || o_A !== 6'd5) begin
            errors++; $display("FAIL show_next_held: got state=%0d done=%b led=%0d A=%0d expected 0/0/8/5",
                               o_state, o_done, o_led, o_A);
        end
    endtask

    task automatic test_clr_with_next();
        logic [N-1:0] sw;
        sw = N'($urandom);
        press(1'b1, 1'b0, sw, 0); model_next(sw);
        checks++;
        if (o_state !== 3'd1 || o_A !== sw) begin
            errors++; $display("FAIL load_a: got state=%0d A=%0d expected 1/%0d", o_state, o_A, sw);
        end
        press(1'b1, 1'b1, N'($urandom), 2); model_reset();
        checks++;
        if (o_state !== 3'd0 || {o_A, o_B, o_OP, o_led} !== '0 || o_done !== 1'b0) begin
            errors++; $display("FAIL clr_priority: got state=%0d regs=%h done=%b expected 0/0/0",
                               o_state, {o_A, o_B, o_OP, o_led}, o_done);
        end
    endtask

    task automatic test_reset_exec();
        press(1'b1, 1'b0, 6'd7, 0);
        press(1'b1, 1'b0, 6'd2, 0);
        @(negedge clk);
        i_SWs = T_SUB; raw_next = 1'b1;
        repeat (DB + 3) @(negedge clk);
        checks++;
        if (o_state !== 3'd3) begin errors++; $display("FAIL exec_entry: got state=%0d expected 3", o_state); end
        raw_next = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_state, o_A, o_B, o_OP, o_led, o_done} !== '0) begin
            errors++; $display("FAIL reset_in_exec: got %h expected 0", {o_state, o_A, o_B, o_OP, o_led, o_done});
        end
        reset = 1'b0;
        model_reset();
        repeat (LAT + 8) @(negedge clk);
        checks++;
        if (o_state !== 3'd0 || o_done !== 1'b0 || o_led !== '0) begin
            errors++; $display("FAIL no_late_capture: got state=%0d done=%b led=%0d expected 0/0/0", o_state, o_done, o_led);
        end
    endtask

`ifdef ALU_SEQ_OPCHECK_EN
    task automatic test_opcheck();
        press(1'b1, 1'b0, 6'd12, 0); model_next(6'd12);
        press(1'b1, 1'b0, 6'd4, 0);  model_next(6'd4);
        press(1'b1, 1'b0, 6'b111111, 0); model_next(6'b111111);
        checks++;
        if (o_op_err !== 1'b1 || o_OP !== m_op || o_state !== 3'd2) begin
            errors++; $display("FAIL op_reject: got err=%b OP=%h state=%0d expected 1/%h/2", o_op_err, o_OP, o_state, m_op);
        end
        @(negedge clk);
        i_SWs = T_SUB; raw_next = 1'b1;
        repeat (DB + 3) @(negedge clk);
        checks++;
        if (o_op_err !== 1'b0 || o_state !== 3'd3 || o_OP !== T_SUB) begin
            errors++; $display("FAIL op_accept: got err=%b state=%0d OP=%h expected 0/3/%h", o_op_err, o_state, o_OP, T_SUB);
        end
        raw_next = 1'b0;
        model_next(T_SUB);
        repeat (DB + 4) @(negedge clk);
        checks++;
        if (o_led !== m_led || o_done !== 1'b1) begin
            errors++; $display("FAIL op_accept_result: got led=%h done=%b expected %h/1", o_led, o_done, m_led);
        end
    endtask
`endif

    task automatic test_random();
        logic [N-1:0] sw;
        logic         use_clr;
        press(1'b0, 1'b1, '0, 0); model_reset();
        for (int it = 0; it < 60; it++) begin
            use_clr = ($urandom_range(0, 9) < 2);
            if (m_state == 2 && $urandom_range(0, 3) != 0) sw = VALID_OPS[$urandom_range(0, 7)];
            else sw = N'($urandom);
            press(~use_clr, use_clr, sw, $urandom_range(0, 6));
            if (use_clr) model_reset(); else model_next(sw);
            checks++;
            if ({o_state, o_A, o_B, o_OP, o_led, o_done} !== {3'(m_state), m_a, m_b, m_op, m_led, m_done}) begin
                errors++;
                $display("FAIL random_%0d: got st=%0d A=%h B=%h OP=%h led=%h done=%b expected st=%0d A=%h B=%h OP=%h led=%h done=%b",
                         it, o_state, o_A, o_B, o_OP, o_led, o_done, m_state, m_a, m_b, m_op, m_led, m_done);
            end
`ifdef ALU_SEQ_OPCHECK_EN
            checks++;
            if (o_op_err !== m_err) begin
                errors++; $display("FAIL random_err_%0d: got %b expected %b", it, o_op_err, m_err);
            end
`endif
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_glitch();
        test_sequence();
        test_show_next();
        test_clr_with_next();
        test_reset_exec();
`ifdef ALU_SEQ_OPCHECK_EN
        test_opcheck();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Single-button operand/opcode sequencer for the board-level ALU datapath. It replaces the one-hot three-button load scheme.
- Walks the user through loading A, B and OP from the switches, waits out the ALU latency, then latches and holds the result for the LEDs.
- Sits between the board I/O (switches, buttons, LEDs) and the ALU instance, and owns the A/B/OP registers.

Parameters:
- N_BITS, 6, operand/opcode/result width.
- DB_CYCLES, 16, number of consecutive stable-high samples required to accept a button press. Minimum 1.
- ALU_LAT, 1, clock cycles from operands/opcode stable to a valid ALU result. Range 0..15.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- i_SWs  in  N_BITS  switch value to capture.
- i_btn_next  in  1  raw "next" button, asynchronous to clock.
- i_btn_clr  in  1  raw "clear" button, asynchronous to clock.
- i_alu_res  in  N_BITS  result from the ALU.
- o_A  out  N_BITS  operand A register to the ALU.
- o_B  out  N_BITS  operand B register to the ALU.
- o_OP  out  N_BITS  opcode register to the ALU.
- o_led  out  N_BITS  held result for display.
- o_state  out  3  current FSM state code, for debug LEDs.
- o_done  out  1  high while a valid result is shown.

Behaviour:
- Clocking and reset: one clock. reset is synchronous and active-high. All state changes on posedge clock.
- Reset values:
  - o_A, o_B, o_OP, o_led = 0; o_done = 0.
  - FSM = S_LOAD_A; o_state = 3'd0.
  - Debounce counters and synchronisers = 0.
- Button conditioning, per button:
  - 2-flop synchroniser, then debounce.
  - Debounced level goes high after DB_CYCLES consecutive high synchronised samples. It goes low after DB_CYCLES consecutive low samples.
  - A one-cycle press pulse fires on the debounced 0->1 edge only. Holding the button produces exactly one pulse.
  - Latency from a clean raw press to the pulse: 2 + DB_CYCLES cycles.
- FSM states and codes: S_LOAD_A=0, S_LOAD_B=1, S_LOAD_OP=2, S_EXEC=3, S_SHOW=4.
- S_LOAD_A: on next pulse, o_A <= i_SWs, go to S_LOAD_B.
- S_LOAD_B: on next pulse, o_B <= i_SWs, go to S_LOAD_OP.
- S_LOAD_OP: on next pulse, o_OP <= i_SWs, load the wait counter with ALU_LAT, go to S_EXEC.
- S_EXEC:
  - Decrement the counter each cycle.
  - When the counter is 0, o_led <= i_alu_res and o_done <= 1, go to S_SHOW.
  - With ALU_LAT=0 the capture happens in the first S_EXEC cycle.
  - Next pulses arriving in S_EXEC are ignored.
- S_SHOW:
  - o_led and o_done hold.
  - On next pulse: o_done <= 0, go to S_LOAD_A.
  - o_A, o_B, o_OP and o_led keep their values until overwritten, so the previous result stays visible while reloading.
- Clear pulse, any state:
  - o_A, o_B, o_OP, o_led <= 0; o_done <= 0; go to S_LOAD_A.
  - Clear has priority over a simultaneous next pulse.
- Switch changes outside a capture cycle have no effect.
- reset asserted mid-sequence (including during S_EXEC) gives the reset values on the next edge; the wait counter is abandoned.
- o_state is registered and equals the current state code.

Optional Feature:
- Macro: ALU_SEQ_OPCHECK_EN.
- Defined:
  - In S_LOAD_OP, a next pulse with i_SWs not in the package's valid-opcode list is rejected. o_OP is unchanged and the FSM stays in S_LOAD_OP.
  - An extra output o_op_err (1 bit, reset 0) is driven. It is set on a reject and cleared on the next accepted capture or clear.
- Undefined: any opcode is accepted; port o_op_err is absent.

Decomposition:
- Package alu_pkg:
  - State encoding constants S_LOAD_A..S_SHOW.
  - Opcode constants: ADD=6'b100000, SUB=100010, AND=100100, OR=100101, XOR=100110, NOR=100111, SRA=000011, SRL=000010.
  - Function is_valid_op.
- Sub-module btn_debounce: synchroniser, debounce counter and edge pulse, parameterised by DB_CYCLES. Instantiated twice (next, clr).

Test Plan:
- Raw next glitch high for DB_CYCLES-1 cycles, then low -> no pulse; FSM stays S_LOAD_A; o_A=0.
- Press next with SWs=6'd5, 6'd3, 6'b100000 (ADD); ALU returns 6'd8 after 1 cycle -> o_A=5, o_B=3, o_OP=0x20; o_led=8 and o_done=1 exactly ALU_LAT+1 cycles after OP capture; o_state=4.
- In S_SHOW press next -> o_done=0, o_state=0, o_led still 8; a held button produces only one transition.
- next and clr pulses in the same cycle while in S_LOAD_B -> state S_LOAD_A; o_A=o_B=o_OP=o_led=0.
- Assert reset during S_EXEC with ALU_LAT=4 -> on the next edge all outputs 0 and o_state=0; no late result capture.
- With ALU_SEQ_OPCHECK_EN, press next with SWs=6'b111111 in S_LOAD_OP -> o_op_err=1, o_OP unchanged, state stays 2. A following press with 6'b100010 -> o_op_err=0, state goes to 3.
